seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Parametrised multiplexed LED-digit scanner, successor to the fixed 3-digit button demo.
//   Holds one segment pattern per digit, written over a simple write port.
//   Time-multiplexes the digits with anti-ghost blanking and PWM brightness.
//   Optional frame-synchronous (double-buffered) update; sits between board pins and any pattern source.
// PARAMETERS
//   NUM_DIGITS   3       digits scanned (>=2)
//   NUM_SEGS     8       segment lines per digit (incl. DP)
//   DIGIT_TICKS  262144  clock cycles per digit slot (>BLANK_TICKS)
//   BLANK_TICKS  512     cycles at slot start with all digits off (anti-ghost)
//   BRIGHT_BITS  4       brightness/PWM width
//   DIGIT_ACT_LO 1       1: DIGIT select active-low; 0: active-high
//   SEG_ACT_LO   0       1: SEG lines active-low; 0: active-high
//   FRAME_SYNC   0       1: writes go to shadow regs, applied at frame end
// PORTS
//   OSC_50M  in   1                  system clock, all logic on rising edge
//   RESET    in   1                  synchronous, active-high reset
//   WR_EN    in   1                  write strobe, one write per cycle
//   WR_ADDR  in   AW=max(1,clog2(ND)) digit index to write
//   WR_DATA  in   NUM_SEGS           segment pattern, bit=1 means lit (logical)
//   BRIGHT   in   BRIGHT_BITS        brightness, 0=off, 2^B-1=max
//   DIGIT    out  NUM_DIGITS         digit select, registered
//   SEG      out  NUM_SEGS           segment drive, registered
//   FRAME    out  1                  1-cycle pulse, end of each full scan
// BEHAVIOUR
//   Reset: tick=0, scan=0, pwm=0, all pattern/shadow regs=0; DIGIT=all-off, SEG=all-off, FRAME=0.
//   "off" = all ones when the matching *_ACT_LO=1, else all zeros.
//   tick: 0..DIGIT_TICKS-1; at DIGIT_TICKS-1 wraps to 0 and scan advances; scan NUM_DIGITS-1 -> 0.
//   pwm: free-running BRIGHT_BITS counter, +1 every cycle, wraps.
//   lit = (tick >= BLANK_TICKS) && (pwm < BRIGHT); BRIGHT sampled each cycle, no latch.
//   Outputs registered, 1-cycle latency from the state of cycle n:
//     lit: DIGIT = one-hot(scan) in select polarity; SEG = pat[scan] in seg polarity.
//     !lit: DIGIT = all-off, SEG = all-off. Never two digits selected.
//   FRAME <= (tick==DIGIT_TICKS-1 && scan==NUM_DIGITS-1); period = NUM_DIGITS*DIGIT_TICKS.
//   Writes: WR_ADDR >= NUM_DIGITS ignored (no reg changes).
//   FRAME_SYNC=0: pat[WR_ADDR] updated at the edge; on SEG 2 cycles after WR_EN if that digit is lit.
//   FRAME_SYNC=1: shadow[WR_ADDR] updated; all pat <= shadow on frame-end cycle (FRAME condition).
//     A write on the frame-end cycle lands in shadow and shows next frame, not this one.
//   RESET mid-scan: next edge returns everything to reset values, pattern regs cleared; RESET overrides WR_EN.
//   No combinational path input->output.
// TESTING (ND=3, DIGIT_TICKS=8, BLANK_TICKS=2, BRIGHT_BITS=2, ACT_LO=1/0, FRAME_SYNC=0 unless noted)
//   Hold RESET 3 cycles -> DIGIT=3'b111, SEG=8'h00, FRAME=0 throughout and 1 cycle after release.
//   Write 0:A5,1:3C,2:FF, BRIGHT=3 -> per 8-cycle slot digit k low 4 cycles (pwm 2,0,1,2 phases), SEG=pat[k] only then; FRAME every 24.
//   BRIGHT=0 -> DIGIT stays 111, SEG stays 00, FRAME still pulses every 24 cycles.
//   WR_EN with WR_ADDR=3, data 0x55 -> all three patterns unchanged over next full frame.
//   FRAME_SYNC=1: write 1:0x81 mid-frame -> SEG shows old pat for digit1 until after next FRAME, then 0x81.
//   Assert RESET during digit 1 lit window -> next cycle DIGIT=111, SEG=00; after release scan restarts at digit 0, patterns 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed LED-digit scanner with anti-ghost blanking and PWM brightness
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 3,
   parameter int NUM_SEGS     = 8,
   parameter int DIGIT_TICKS  = 262144,
   parameter int BLANK_TICKS  = 512,
   parameter int BRIGHT_BITS  = 4,
   parameter int DIGIT_ACT_LO = 1,
   parameter int SEG_ACT_LO   = 0,
   parameter int FRAME_SYNC   = 0,
   localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                   OSC_50M,
   input  logic                   RESET,
   input  logic                   WR_EN,
   input  logic [AW-1:0]          WR_ADDR,
   input  logic [NUM_SEGS-1:0]    WR_DATA,
   input  logic [BRIGHT_BITS-1:0] BRIGHT,
   output logic [NUM_DIGITS-1:0]  DIGIT,
   output logic [NUM_SEGS-1:0]    SEG,
   output logic                   FRAME
);

   localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
   localparam logic [TW-1:0]         TICK_LAST = TW'(DIGIT_TICKS - 1);
   localparam logic [TW-1:0]         BLANK_END = TW'(BLANK_TICKS);
   localparam logic [AW-1:0]         SCAN_LAST = AW'(NUM_DIGITS - 1);
   localparam logic [AW:0]           ADDR_LIM  = (AW + 1)'(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = {NUM_DIGITS{DIGIT_ACT_LO != 0}};
   localparam logic [NUM_SEGS-1:0]   SEG_OFF   = {NUM_SEGS{SEG_ACT_LO != 0}};

   logic [TW-1:0]          tick_q, tick_d;
   logic [AW-1:0]          scan_q, scan_d;
   logic [BRIGHT_BITS-1:0] pwm_q, pwm_d;
   logic [NUM_SEGS-1:0]    pat_q    [NUM_DIGITS];
   logic [NUM_SEGS-1:0]    pat_d    [NUM_DIGITS];
   logic [NUM_SEGS-1:0]    shadow_q [NUM_DIGITS];
   logic [NUM_SEGS-1:0]    shadow_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]  digit_q, digit_d;
   logic [NUM_SEGS-1:0]    seg_q, seg_d;
   logic                   frame_q, frame_d;
   logic                   frame_end;
   logic                   lit;
   logic                   wr_ok;

   always_comb begin
      frame_end = (tick_q == TICK_LAST) && (scan_q == SCAN_LAST);
      tick_d    = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      scan_d    = scan_q;
      if (tick_q == TICK_LAST) begin
         scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
      end
      pwm_d   = pwm_q + 1'b1;
      frame_d = frame_end;
      lit     = (tick_q >= BLANK_END) && (pwm_q < BRIGHT);
      wr_ok   = WR_EN && ({1'b0, WR_ADDR} < ADDR_LIM);

      // Shadow copy uses the pre-write shadow, so a frame-end write waits a full frame.
      pat_d    = pat_q;
      shadow_d = shadow_q;
      if (FRAME_SYNC != 0) begin
         if (frame_end) begin
            pat_d = shadow_q;
         end
         if (wr_ok) begin
            shadow_d[WR_ADDR] = WR_DATA;
         end
      end else if (wr_ok) begin
         pat_d[WR_ADDR] = WR_DATA;
      end

      digit_d = DIGIT_OFF;
      seg_d   = SEG_OFF;
      if (lit) begin
         digit_d = (NUM_DIGITS'(1) << scan_q) ^ DIGIT_OFF;
         seg_d   = pat_q[scan_q] ^ SEG_OFF;
      end
   end

   always_ff @(posedge OSC_50M) begin
      if (RESET) begin
         tick_q  <= '0;
         scan_q  <= '0;
         pwm_q   <= '0;
         digit_q <= DIGIT_OFF;
         seg_q   <= SEG_OFF;
         frame_q <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            pat_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         tick_q   <= tick_d;
         scan_q   <= scan_d;
         pwm_q    <= pwm_d;
         digit_q  <= digit_d;
         seg_q    <= seg_d;
         frame_q  <= frame_d;
         pat_q    <= pat_d;
         shadow_q <= shadow_d;
      end
   end

   assign DIGIT = digit_q;
   assign SEG   = seg_q;
   assign FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized bench for seg_scan_driver against a cycle-count reference model
module tb_seg_scan_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [1:0] bright = '0;
   logic [2:0] digit0, digit1;
   logic [7:0] seg0, seg1;
   logic       frame0, frame1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .NUM_DIGITS(3), .NUM_SEGS(8), .DIGIT_TICKS(8), .BLANK_TICKS(2), .BRIGHT_BITS(2),
      .DIGIT_ACT_LO(1), .SEG_ACT_LO(0), .FRAME_SYNC(0)
   ) u_dut (
      .OSC_50M(clk), .RESET(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .BRIGHT(bright), .DIGIT(digit0), .SEG(seg0), .FRAME(frame0)
   );

   seg_scan_driver #(
      .NUM_DIGITS(3), .NUM_SEGS(8), .DIGIT_TICKS(8), .BLANK_TICKS(2), .BRIGHT_BITS(2),
      .DIGIT_ACT_LO(1), .SEG_ACT_LO(0), .FRAME_SYNC(1)
   ) u_dut_fs (
      .OSC_50M(clk), .RESET(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .BRIGHT(bright), .DIGIT(digit1), .SEG(seg1), .FRAME(frame1)
   );

   // Reference: everything derives from the cycle count t since reset release.
   int         t = 0;
   int         m_tick, m_scan, m_pwm;
   bit         m_lit;
   logic [7:0] m_pat [3] = '{default: 8'h00};
   logic [7:0] m_sh  [3] = '{default: 8'h00};
   logic [7:0] m_pfs [3] = '{default: 8'h00};
   logic [2:0] exp_digit = 3'b111;
   logic [7:0] exp_seg0 = 8'h00, exp_seg1 = 8'h00;
   logic       exp_frame = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         t = 0;
         for (int i = 0; i < 3; i++) begin
            m_pat[i] = 8'h00; m_sh[i] = 8'h00; m_pfs[i] = 8'h00;
         end
         exp_digit = 3'b111; exp_seg0 = 8'h00; exp_seg1 = 8'h00; exp_frame = 1'b0;
      end else begin
         m_tick = t % 8;
         m_scan = (t / 8) % 3;
         m_pwm  = t % 4;
         m_lit  = (m_tick >= 2) && (m_pwm < int'(bright));
         exp_digit = m_lit ? ~(3'b001 << m_scan) : 3'b111;
         exp_seg0  = m_lit ? m_pat[m_scan] : 8'h00;
         exp_seg1  = m_lit ? m_pfs[m_scan] : 8'h00;
         exp_frame = (t % 24) == 23;
         if (exp_frame) begin
            for (int i = 0; i < 3; i++) m_pfs[i] = m_sh[i];
         end
         if (wr_en && wr_addr < 2'd3) begin
            m_pat[wr_addr] = wr_data;
            m_sh[wr_addr]  = wr_data;
         end
         t++;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({digit0, seg0, frame0, digit1, seg1, frame1} !== {3'b111, 8'h00, 1'b0, 3'b111, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got d=%b s=%h f=%b / d=%b s=%h f=%b", i, digit0, seg0, frame0, digit1, seg1, frame1);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({digit0, seg0, frame0} !== {3'b111, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_release got d=%b s=%h f=%b exp d=111 s=00 f=0", digit0, seg0, frame0);
      end
   endtask

   task automatic test_scan();
      logic [7:0] pats [3];
      int         on_cnt [3];
      int         frames;
      bit         seen;
      pats = '{8'hA5, 8'h3C, 8'hFF};
      bright = 2'd3;
      for (int k = 0; k < 3; k++) begin
         wr_en = 1'b1; wr_addr = 2'(k); wr_data = pats[k];
         @(negedge clk);
         checks++;
         if ({digit0, seg0, frame0, digit1, seg1, frame1} !== {exp_digit, exp_seg0, exp_frame, exp_digit, exp_seg1, exp_frame}) begin
            errors++;
            $display("FAIL scan_write_model got %b %h %b %b %h %b exp %b %h %b %h", digit0, seg0, frame0, digit1, seg1, frame1, exp_digit, exp_seg0, exp_frame, exp_seg1);
         end
      end
      wr_en = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = frame0;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL scan_frame_wait got no FRAME within 30 cycles exp a pulse");
      end
      on_cnt = '{0, 0, 0};
      frames = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         checks++;
         if ({digit0, seg0, frame0, digit1, seg1, frame1} !== {exp_digit, exp_seg0, exp_frame, exp_digit, exp_seg1, exp_frame}) begin
            errors++;
            $display("FAIL scan_model got %b %h %b %b %h %b exp %b %h %b %h", digit0, seg0, frame0, digit1, seg1, frame1, exp_digit, exp_seg0, exp_frame, exp_seg1);
         end
         frames += int'(frame0);
         for (int k = 0; k < 3; k++) begin
            if (digit0 == ~(3'b001 << k)) begin
               on_cnt[k]++;
               checks++;
               if (seg0 !== pats[k]) begin
                  errors++;
                  $display("FAIL scan_seg digit=%0d got %h exp %h", k, seg0, pats[k]);
               end
            end
         end
         if (digit0 == 3'b111) begin
            checks++;
            if (seg0 !== 8'h00) begin
               errors++;
               $display("FAIL scan_blank_seg got %h exp 00", seg0);
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (on_cnt[k] != 4) begin
            errors++;
            $display("FAIL scan_duty digit=%0d got %0d exp 4", k, on_cnt[k]);
         end
      end
      checks++;
      if (frames != 1) begin
         errors++;
         $display("FAIL scan_frame_count got %0d exp 1", frames);
      end
   endtask

   task automatic test_bright_zero();
      int frames;
      bright = 2'd0;
      @(negedge clk);
      @(negedge clk);
      frames = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         checks++;
         if ({digit0, seg0, digit1, seg1} !== {3'b111, 8'h00, 3'b111, 8'h00}) begin
            errors++;
            $display("FAIL bright_zero got d=%b s=%h d=%b s=%h exp 111 00", digit0, seg0, digit1, seg1);
         end
         frames += int'(frame0);
      end
      checks++;
      if (frames != 1) begin
         errors++;
         $display("FAIL bright_zero_frames got %0d exp 1", frames);
      end
   endtask

   task automatic test_bad_addr();
      bright = 2'd3;
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h55;
      @(negedge clk);
      wr_en = 1'b0;
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         checks++;
         if ({digit0, seg0, frame0, digit1, seg1, frame1} !== {exp_digit, exp_seg0, exp_frame, exp_digit, exp_seg1, exp_frame}) begin
            errors++;
            $display("FAIL bad_addr_model got %b %h %b %b %h %b exp %b %h %b %h", digit0, seg0, frame0, digit1, seg1, frame1, exp_digit, exp_seg0, exp_frame, exp_seg1);
         end
         if (seg0 == 8'h55 || seg1 == 8'h55) begin
            checks++;
            errors++;
            $display("FAIL bad_addr_leak got %h/%h exp no 55", seg0, seg1);
         end
      end
   endtask

   task automatic test_frame_sync();
      bit seen;
      int old_hits, new_hits;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = frame1;
      end
      repeat (5) @(negedge clk);
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h81;
      @(negedge clk);
      wr_en = 1'b0;
      seen = 1'b0;
      old_hits = 0; new_hits = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         checks++;
         if ({digit0, seg0, frame0, digit1, seg1, frame1} !== {exp_digit, exp_seg0, exp_frame, exp_digit, exp_seg1, exp_frame}) begin
            errors++;
            $display("FAIL fsync_model got %b %h %b %b %h %b exp %b %h %b %h", digit0, seg0, frame0, digit1, seg1, frame1, exp_digit, exp_seg0, exp_frame, exp_seg1);
         end
         if (digit1 == 3'b101) begin
            checks++;
            if (seg1 !== (seen ? 8'h81 : 8'h3C)) begin
               errors++;
               $display("FAIL fsync_seg after_frame=%0d got %h exp %h", seen, seg1, seen ? 8'h81 : 8'h3C);
            end
            if (seen) new_hits++; else old_hits++;
         end
         if (frame1) seen = 1'b1;
      end
      checks++;
      if (old_hits == 0 || new_hits == 0) begin
         errors++;
         $display("FAIL fsync_coverage got old=%0d new=%0d exp both nonzero", old_hits, new_hits);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         if (i % 16 == 0) bright = 2'($urandom_range(0, 3));
         wr_en   = ($urandom_range(0, 2) == 0);
         wr_addr = 2'($urandom_range(0, 3));
         wr_data = 8'($urandom);
         @(negedge clk);
         checks++;
         if ({digit0, seg0, frame0, digit1, seg1, frame1} !== {exp_digit, exp_seg0, exp_frame, exp_digit, exp_seg1, exp_frame}) begin
            errors++;
            $display("FAIL random_model i=%0d got %b %h %b %b %h %b exp %b %h %b %h", i, digit0, seg0, frame0, digit1, seg1, frame1, exp_digit, exp_seg0, exp_frame, exp_seg1);
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit         found;
      logic [2:0] first_dig;
      bright = 2'd3;
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C;
      @(negedge clk);
      wr_en = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = (digit0 == 3'b101);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reset_mid_wait got no digit1 window exp one within 40 cycles");
      end
      rst = 1'b1;
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hEE;
      @(negedge clk);
      checks++;
      if ({digit0, seg0, frame0, digit1, seg1, frame1} !== {3'b111, 8'h00, 1'b0, 3'b111, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid got d=%b s=%h f=%b exp d=111 s=00 f=0", digit0, seg0, frame0);
      end
      rst = 1'b0;
      wr_en = 1'b0;
      first_dig = 3'b111;
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         checks++;
         if ({digit0, seg0, frame0, digit1, seg1, frame1} !== {exp_digit, 8'h00, exp_frame, exp_digit, 8'h00, exp_frame}) begin
            errors++;
            $display("FAIL reset_mid_after got %b %h %b %b %h %b exp %b 00 %b", digit0, seg0, frame0, digit1, seg1, frame1, exp_digit, exp_frame);
         end
         if (first_dig == 3'b111 && digit0 != 3'b111) first_dig = digit0;
      end
      checks++;
      if (first_dig !== 3'b110) begin
         errors++;
         $display("FAIL reset_mid_first_digit got %b exp 110", first_dig);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_bright_zero();
      test_bad_addr();
      test_frame_sync();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
